// File: rtl/switch_port_bridge_pkg.sv
// Shared types for the switch port bridge: flit layout, packet tracker states and
// the header-length decode used to find packet boundaries on egress.
package switch_port_bridge_pkg;

    typedef logic [2:0] port_id_t;

    typedef struct packed {
        logic [3:0]  length;
        port_id_t    dest;
        logic [24:0] payload;
    } flit_t;

    typedef enum logic {
        PKT_IDLE = 1'b0,
        PKT_BODY = 1'b1
    } pkt_state_t;

    localparam int LEN_W = 4;

    // A zero length field is treated as a single-flit packet so the tracker never underflows.
    function automatic logic [LEN_W-1:0] expected_flits(input flit_t head);
        return (head.length == 4'd0) ? 4'd1 : head.length;
    endfunction

endpackage

// File: rtl/switch_port_bridge_fifo.sv
// Show-ahead flit FIFO: head is visible on rd_data whenever not empty, zero otherwise.
module switch_port_bridge_fifo
    import switch_port_bridge_pkg::*;
#(
    parameter int DEPTH = 8
) (
    input  logic                     clk,
    input  logic                     n_rst,
    input  logic                     push,
    input  flit_t                    wr_data,
    input  logic                     pop,
    output flit_t                    rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    flit_t          mem_r [DEPTH];
    logic [AW-1:0]  wr_ptr_r;
    logic [AW-1:0]  rd_ptr_r;
    logic [CW-1:0]  count_r;
    logic           do_push_s;
    logic           do_pop_s;

    assign full      = (count_r == CW'(DEPTH));
    assign empty     = (count_r == CW'(0));
    assign count     = count_r;
    assign do_push_s = push && !full;
    assign do_pop_s  = pop && !empty;
    assign rd_data   = empty ? flit_t'('0) : mem_r[rd_ptr_r];

    // Storage array; contents are don't-care until written, so no reset.
    always_ff @(posedge clk) begin
        if (do_push_s) begin
            mem_r[wr_ptr_r] <= wr_data;
        end
    end

    // Pointers wrap naturally at the power-of-two depth; occupancy tracks push/pop.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            wr_ptr_r <= AW'(0);
            rd_ptr_r <= AW'(0);
            count_r  <= CW'(0);
        end else begin
            if (do_push_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CW'(1);
                2'b01:   count_r <= count_r - CW'(1);
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/switch_port_bridge.sv
// Per-port ingress/egress flit buffering between external streams and switch ports.
// Define SWITCH_PORT_BRIDGE_STATS_EN to add saturating per-port flit/packet counters.
module switch_port_bridge
    import switch_port_bridge_pkg::*;
#(
    parameter int NUM_PORTS  = 2,
    parameter int FIFO_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 n_rst,
    input  flit_t                in_flit           [NUM_PORTS],
    input  logic [NUM_PORTS-1:0] in_valid,
    output logic [NUM_PORTS-1:0] in_ready,
    output flit_t                sw_in             [NUM_PORTS],
    output logic [NUM_PORTS-1:0] sw_data_ready_in,
    input  logic [NUM_PORTS-1:0] sw_in_credit,
    input  flit_t                sw_out            [NUM_PORTS],
    input  logic [NUM_PORTS-1:0] sw_data_ready_out,
    output logic [NUM_PORTS-1:0] sw_packet_sent,
    output flit_t                eg_flit           [NUM_PORTS],
    output logic [NUM_PORTS-1:0] eg_valid,
    input  logic [NUM_PORTS-1:0] eg_ready,
    output logic [NUM_PORTS-1:0] overflow
`ifdef SWITCH_PORT_BRIDGE_STATS_EN
    ,
    output logic [31:0]          stat_in_flits     [NUM_PORTS],
    output logic [31:0]          stat_eg_pkts      [NUM_PORTS]
`endif
);

    localparam int CW = $clog2(FIFO_DEPTH) + 1;

    for (genvar p = 0; p < NUM_PORTS; p++) begin : g_port
        logic             in_full_s;
        logic             in_empty_s;
        logic [CW-1:0]    in_count_s;
        flit_t            in_head_s;
        logic             issue_s;
        logic             eg_full_s;
        logic             eg_empty_s;
        logic [CW-1:0]    eg_count_s;
        flit_t            eg_head_s;
        logic             eg_pop_s;
        logic             unused_count_s;
        flit_t            sw_in_r;
        logic             strobe_r;
        logic             overflow_r;
        logic             sent_r;
        pkt_state_t       state_r;
        logic [LEN_W-1:0] remaining_r;

        switch_port_bridge_fifo #(.DEPTH(FIFO_DEPTH)) u_in_fifo (
            .clk     (clk),
            .n_rst   (n_rst),
            .push    (in_valid[p]),
            .wr_data (in_flit[p]),
            .pop     (issue_s),
            .rd_data (in_head_s),
            .full    (in_full_s),
            .empty   (in_empty_s),
            .count   (in_count_s)
        );

        // Egress drops strobes while full; the FIFO itself refuses the push.
        switch_port_bridge_fifo #(.DEPTH(FIFO_DEPTH)) u_eg_fifo (
            .clk     (clk),
            .n_rst   (n_rst),
            .push    (sw_data_ready_out[p]),
            .wr_data (sw_out[p]),
            .pop     (eg_pop_s),
            .rd_data (eg_head_s),
            .full    (eg_full_s),
            .empty   (eg_empty_s),
            .count   (eg_count_s)
        );

        assign issue_s             = !in_empty_s && sw_in_credit[p];
        assign eg_pop_s            = !eg_empty_s && eg_ready[p];
        assign unused_count_s      = ^{in_count_s, eg_count_s};
        assign in_ready[p]         = !in_full_s;
        assign sw_in[p]            = sw_in_r;
        assign sw_data_ready_in[p] = strobe_r;
        assign eg_flit[p]          = eg_head_s;
        assign eg_valid[p]         = !eg_empty_s;
        assign overflow[p]         = overflow_r;
        assign sw_packet_sent[p]   = sent_r;

        // Issue the ingress head to the switch with a one-cycle strobe; sw_in holds between issues.
        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                sw_in_r  <= flit_t'('0);
                strobe_r <= 1'b0;
            end else begin
                strobe_r <= issue_s;
                if (issue_s) begin
                    sw_in_r <= in_head_s;
                end
            end
        end

        // Sticky flag for a switch output strobe arriving while egress is full.
        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                overflow_r <= 1'b0;
            end else if (sw_data_ready_out[p] && eg_full_s) begin
                overflow_r <= 1'b1;
            end
        end

        // Packet boundary tracker on egress pops; pulse follows the pop of the last flit.
        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                state_r     <= PKT_IDLE;
                remaining_r <= LEN_W'(0);
                sent_r      <= 1'b0;
            end else begin
                sent_r <= 1'b0;
                if (eg_pop_s) begin
                    case (state_r)
                        PKT_IDLE: begin
                            if (expected_flits(eg_head_s) == LEN_W'(1)) begin
                                sent_r <= 1'b1;
                            end else begin
                                remaining_r <= expected_flits(eg_head_s) - LEN_W'(1);
                                state_r     <= PKT_BODY;
                            end
                        end
                        PKT_BODY: begin
                            remaining_r <= remaining_r - LEN_W'(1);
                            if (remaining_r == LEN_W'(1)) begin
                                sent_r  <= 1'b1;
                                state_r <= PKT_IDLE;
                            end
                        end
                        default: begin
                            state_r     <= PKT_IDLE;
                            remaining_r <= LEN_W'(0);
                        end
                    endcase
                end
            end
        end

`ifdef SWITCH_PORT_BRIDGE_STATS_EN
        logic [31:0] stat_in_r;
        logic [31:0] stat_pkt_r;

        assign stat_in_flits[p] = stat_in_r;
        assign stat_eg_pkts[p]  = stat_pkt_r;

        // Saturating counters of issued ingress flits and completed egress packets.
        always_ff @(posedge clk or negedge n_rst) begin
            if (!n_rst) begin
                stat_in_r  <= 32'd0;
                stat_pkt_r <= 32'd0;
            end else begin
                if (issue_s && (stat_in_r != 32'hFFFF_FFFF)) begin
                    stat_in_r <= stat_in_r + 32'd1;
                end
                if (sent_r && (stat_pkt_r != 32'hFFFF_FFFF)) begin
                    stat_pkt_r <= stat_pkt_r + 32'd1;
                end
            end
        end
`endif
    end

endmodule

// File: tb/tb_switch_port_bridge.sv
// Directed bench for switch_port_bridge: reset, ingress ordering/backpressure,
// egress packet pulses, overflow and mid-packet reset.
module tb_switch_port_bridge;
    import switch_port_bridge_pkg::*;

    localparam int NP = 2;

    logic          clk;
    logic          n_rst;
    flit_t         in_flit [NP];
    logic [NP-1:0] in_valid;
    logic [NP-1:0] in_ready;
    flit_t         sw_in [NP];
    logic [NP-1:0] sw_data_ready_in;
    logic [NP-1:0] sw_in_credit;
    flit_t         sw_out [NP];
    logic [NP-1:0] sw_data_ready_out;
    logic [NP-1:0] sw_packet_sent;
    flit_t         eg_flit [NP];
    logic [NP-1:0] eg_valid;
    logic [NP-1:0] eg_ready;
    logic [NP-1:0] overflow;
`ifdef SWITCH_PORT_BRIDGE_STATS_EN
    logic [31:0]   stat_in_flits [NP];
    logic [31:0]   stat_eg_pkts [NP];
`endif

    int nvec = 0;
    int nerr = 0;

    switch_port_bridge #(.NUM_PORTS(NP), .FIFO_DEPTH(8)) dut (
        .clk               (clk),
        .n_rst             (n_rst),
        .in_flit           (in_flit),
        .in_valid          (in_valid),
        .in_ready          (in_ready),
        .sw_in             (sw_in),
        .sw_data_ready_in  (sw_data_ready_in),
        .sw_in_credit      (sw_in_credit),
        .sw_out            (sw_out),
        .sw_data_ready_out (sw_data_ready_out),
        .sw_packet_sent    (sw_packet_sent),
        .eg_flit           (eg_flit),
        .eg_valid          (eg_valid),
        .eg_ready          (eg_ready),
        .overflow          (overflow)
`ifdef SWITCH_PORT_BRIDGE_STATS_EN
        ,
        .stat_in_flits     (stat_in_flits),
        .stat_eg_pkts      (stat_eg_pkts)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic flit_t mk(input logic [3:0] len, input logic [24:0] pl);
        flit_t f;
        f.length  = len;
        f.dest    = 3'd0;
        f.payload = pl;
        return f;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        flit_t r;
        r = mk(4'd1, 25'h0_00AA);
        n_rst = 1'b0;
        in_valid = 2'b01;
        in_flit[0] = r;
        in_flit[1] = flit_t'('0);
        sw_in_credit = 2'b11;
        sw_out[0] = flit_t'('0);
        sw_out[1] = flit_t'('0);
        sw_data_ready_out = 2'b00;
        eg_ready = 2'b00;
        repeat (3) step();
        nvec++; if (in_ready !== 2'b11) begin nerr++; $display("FAIL rst_in_ready got %b want 11", in_ready); end
        nvec++; if (sw_data_ready_in !== 2'b00) begin nerr++; $display("FAIL rst_strobe got %b want 00", sw_data_ready_in); end
        nvec++; if ({eg_valid, overflow, sw_packet_sent} !== 6'b0) begin nerr++; $display("FAIL rst_flags got %b want 000000", {eg_valid, overflow, sw_packet_sent}); end
        nvec++; if (sw_in[0] !== flit_t'('0) || eg_flit[0] !== flit_t'('0)) begin nerr++; $display("FAIL rst_data got %h/%h want 0", sw_in[0], eg_flit[0]); end
        n_rst = 1'b1;
        step();
        in_valid = 2'b00;
        nvec++; if (sw_data_ready_in[0] !== 1'b0) begin nerr++; $display("FAIL rst_release_early got %b want 0", sw_data_ready_in[0]); end
        step();
        nvec++; if (sw_data_ready_in[0] !== 1'b1 || sw_in[0] !== r) begin nerr++; $display("FAIL rst_first_issue got %b/%h want 1/%h", sw_data_ready_in[0], sw_in[0], r); end
        step();
        nvec++; if (sw_data_ready_in[0] !== 1'b0) begin nerr++; $display("FAIL rst_strobe_width got %b want 0", sw_data_ready_in[0]); end
    endtask

    task automatic test_ingress_order();
        flit_t f [3];
        for (int i = 0; i < 3; i++) f[i] = mk(4'd3, 25'h100 + 25'(i));
        sw_in_credit = 2'b11;
        for (int s = 0; s < 6; s++) begin
            in_valid[0] = (s < 3);
            if (s < 3) in_flit[0] = f[s];
            step();
            if (s >= 1 && s <= 3) begin
                nvec++; if (sw_data_ready_in[0] !== 1'b1 || sw_in[0] !== f[s-1]) begin nerr++; $display("FAIL order_%0d got %b/%h want 1/%h", s, sw_data_ready_in[0], sw_in[0], f[s-1]); end
            end else begin
                nvec++; if (sw_data_ready_in[0] !== 1'b0) begin nerr++; $display("FAIL order_idle_%0d got %b want 0", s, sw_data_ready_in[0]); end
            end
        end
    endtask

    task automatic test_full_backpressure();
        flit_t f [9];
        for (int i = 0; i < 9; i++) f[i] = mk(4'd1, 25'h300 + 25'(i));
        sw_in_credit[0] = 1'b0;
        for (int i = 0; i < 9; i++) begin
            nvec++; if (in_ready[0] !== (i < 8)) begin nerr++; $display("FAIL full_ready_%0d got %b want %b", i, in_ready[0], (i < 8)); end
            in_valid[0] = 1'b1;
            in_flit[0] = f[i];
            step();
        end
        in_valid[0] = 1'b0;
        nvec++; if (in_ready !== 2'b10 || sw_data_ready_in[0] !== 1'b0) begin nerr++; $display("FAIL full_hold got %b/%b want 10/0", in_ready, sw_data_ready_in[0]); end
        sw_in_credit[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            step();
            nvec++; if (sw_data_ready_in[0] !== 1'b1 || sw_in[0] !== f[k]) begin nerr++; $display("FAIL drain_%0d got %b/%h want 1/%h", k, sw_data_ready_in[0], sw_in[0], f[k]); end
        end
        step();
        nvec++; if (sw_data_ready_in[0] !== 1'b0 || in_ready[0] !== 1'b1) begin nerr++; $display("FAIL drain_end got %b/%b want 0/1", sw_data_ready_in[0], in_ready[0]); end
    endtask

    task automatic test_egress_packet();
        flit_t pk [4];
        int pulses;
        pulses = 0;
        pk[0] = mk(4'd4, 25'h400);
        for (int i = 1; i < 4; i++) pk[i] = mk(4'd0, 25'h400 + 25'(i));
        eg_ready[0] = 1'b1;
        for (int s = 1; s <= 7; s++) begin
            sw_data_ready_out[0] = (s <= 4);
            if (s <= 4) sw_out[0] = pk[s-1];
            step();
            if (sw_packet_sent[0] === 1'b1) pulses++;
            nvec++; if (sw_packet_sent[0] !== (s == 5)) begin nerr++; $display("FAIL pkt_pulse_%0d got %b want %b", s, sw_packet_sent[0], (s == 5)); end
            if (s <= 4) begin
                nvec++; if (eg_valid[0] !== 1'b1 || eg_flit[0] !== pk[s-1]) begin nerr++; $display("FAIL pkt_head_%0d got %b/%h want 1/%h", s, eg_valid[0], eg_flit[0], pk[s-1]); end
            end
        end
        nvec++; if (pulses != 1 || eg_valid[0] !== 1'b0) begin nerr++; $display("FAIL pkt_count got %0d/%b want 1/0", pulses, eg_valid[0]); end
        eg_ready[0] = 1'b0;
    endtask

    task automatic test_overflow();
        flit_t d [9];
        for (int i = 0; i < 9; i++) d[i] = mk(4'd1, 25'h500 + 25'(i));
        eg_ready = 2'b00;
        for (int i = 0; i < 9; i++) begin
            sw_data_ready_out[0] = 1'b1;
            sw_out[0] = d[i];
            step();
            nvec++; if (overflow[0] !== (i == 8)) begin nerr++; $display("FAIL ovf_%0d got %b want %b", i, overflow[0], (i == 8)); end
        end
        sw_data_ready_out[0] = 1'b0;
        nvec++; if (overflow[1] !== 1'b0 || eg_valid[1] !== 1'b0) begin nerr++; $display("FAIL ovf_port1 got %b/%b want 0/0", overflow[1], eg_valid[1]); end
        eg_ready[0] = 1'b1;
        for (int k = 0; k < 8; k++) begin
            nvec++; if (eg_valid[0] !== 1'b1 || eg_flit[0] !== d[k]) begin nerr++; $display("FAIL ovf_keep_%0d got %b/%h want 1/%h", k, eg_valid[0], eg_flit[0], d[k]); end
            step();
        end
        nvec++; if (eg_valid[0] !== 1'b0 || overflow[0] !== 1'b1) begin nerr++; $display("FAIL ovf_sticky got %b/%b want 0/1", eg_valid[0], overflow[0]); end
        eg_ready[0] = 1'b0;
    endtask

    task automatic test_reset_mid_packet();
        flit_t one;
        one = mk(4'd1, 25'h7FF);
        eg_ready = 2'b00;
        for (int i = 0; i < 4; i++) begin
            sw_data_ready_out[0] = 1'b1;
            sw_out[0] = (i == 0) ? mk(4'd4, 25'h600) : mk(4'd0, 25'h600 + 25'(i));
            step();
        end
        sw_data_ready_out[0] = 1'b0;
        eg_ready[0] = 1'b1;
        step();
        step();
        eg_ready[0] = 1'b0;
        n_rst = 1'b0;
        #2;
        nvec++; if ({eg_valid[0], overflow[0], sw_packet_sent[0]} !== 3'b000) begin nerr++; $display("FAIL mid_rst_clear got %b want 000", {eg_valid[0], overflow[0], sw_packet_sent[0]}); end
        step();
        n_rst = 1'b1;
        sw_data_ready_out[0] = 1'b1;
        sw_out[0] = one;
        eg_ready[0] = 1'b1;
        step();
        sw_data_ready_out[0] = 1'b0;
        nvec++; if (sw_packet_sent[0] !== 1'b0 || eg_flit[0] !== one) begin nerr++; $display("FAIL mid_rst_push got %b/%h want 0/%h", sw_packet_sent[0], eg_flit[0], one); end
        step();
        nvec++; if (sw_packet_sent[0] !== 1'b1) begin nerr++; $display("FAIL mid_rst_pulse got %b want 1", sw_packet_sent[0]); end
        step();
        nvec++; if (sw_packet_sent[0] !== 1'b0) begin nerr++; $display("FAIL mid_rst_pulse_end got %b want 0", sw_packet_sent[0]); end
        eg_ready[0] = 1'b0;
    endtask

    initial begin
        test_reset();
        test_ingress_order();
        test_full_backpressure();
        test_egress_packet();
        test_overflow();
        test_reset_mid_packet();
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
